// File: rtl/semafor_pietoni.sv
// semafor_pietoni
// ---------------
// Pedestrian-crossing controller. It waits for the vehicle controller to
// report that its cycle is done, runs a timed pedestrian phase, and then
// hands control back to the vehicle side.
//
// Parameters
//   SEC          clock cycles per one-second tick (>= 2)
//   T_SIGURANTA  all-red clearance before pedestrian green, seconds
//   T_VERDE      steady pedestrian green, seconds
//   T_CLIPIRE    blinking pedestrian green, seconds (T_VERDE+T_CLIPIRE <= 31)
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-low reset
//   intretinere     maintenance request, asynchronous level
//   Continuare_v    vehicle cycle done, asynchronous level
//   Continuare_s_v  start request to the vehicle controller
//   Verde_pieton    pedestrian green lamp
//   Rosu_pieton     pedestrian red lamp
//   afisaj          seconds left in the pedestrian phase, 0 outside green
//   stare_o         current FSM state, for debug and checkers
//
// Handoff between the two controllers (level based, no valid/ready pair):
// Continuare_s_v is held high by this block while it sits in PREDARE and
// the vehicle side acts on its rising edge. Continuare_v is held high by the
// vehicle side while it is in its Done state. The pedestrian phase starts
// only when the synchronized Continuare_v is seen high in ASTEPTARE, and
// PREDARE is left only once the synchronized Continuare_v has dropped, so
// each rising edge of Continuare_v starts exactly one pedestrian phase.

module semafor_pietoni #(
    parameter logic [23:0] SEC         = 24'd10000000,
    parameter int unsigned T_SIGURANTA = 1,
    parameter int unsigned T_VERDE     = 10,
    parameter int unsigned T_CLIPIRE   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       intretinere,
    input  logic       Continuare_v,
    output logic       Continuare_s_v,
    output logic       Verde_pieton,
    output logic       Rosu_pieton,
    output logic [4:0] afisaj,
    output logic [2:0] stare_o
);

    localparam logic [2:0] PREDARE    = 3'd0;
    localparam logic [2:0] ASTEPTARE  = 3'd1;
    localparam logic [2:0] SIGURANTA  = 3'd2;
    localparam logic [2:0] VERDE      = 3'd3;
    localparam logic [2:0] CLIPIRE    = 3'd4;
    localparam logic [2:0] MENTENANTA = 3'd5;

    // A timed state ends on the tick that completes its last second.
    localparam logic [4:0] SIG_LAST   = 5'(T_SIGURANTA - 1);
    localparam logic [4:0] VERDE_LAST = 5'(T_VERDE - 1);
    localparam logic [4:0] CLIP_LAST  = 5'(T_CLIPIRE - 1);
    localparam logic [4:0] VERDE_LOAD = 5'(T_VERDE + T_CLIPIRE);
    localparam logic [4:0] CLIP_LOAD  = 5'(T_CLIPIRE);

    // Two-flop synchronizers for the asynchronous level inputs.
    logic cv_meta_q, cv_s_q;
    logic int_meta_q, int_s_q;

    logic [2:0]  stare_q, stare_d;
    logic [23:0] presc_q, presc_d;
    logic [4:0]  sec_q, sec_d;
    logic        csv_q, csv_d;
    logic        verde_q, verde_d;
    logic        rosu_q, rosu_d;
    logic [4:0]  afisaj_q, afisaj_d;

    logic tick;
    logic intrare;

    assign tick    = (presc_q == SEC - 24'd1);
    assign intrare = (stare_d != stare_q);

    // Next-state logic; maintenance overrides every other transition.
    always_comb begin
        stare_d = stare_q;
        if (int_s_q) begin
            stare_d = MENTENANTA;
        end else begin
            case (stare_q)
                PREDARE:    if (!cv_s_q) stare_d = ASTEPTARE;
                ASTEPTARE:  if (cv_s_q) stare_d = SIGURANTA;
                SIGURANTA:  if (tick && sec_q == SIG_LAST) stare_d = VERDE;
                VERDE:      if (tick && sec_q == VERDE_LAST) stare_d = CLIPIRE;
                CLIPIRE:    if (tick && sec_q == CLIP_LAST) stare_d = PREDARE;
                MENTENANTA: stare_d = PREDARE;
                default:    stare_d = PREDARE;
            endcase
        end
    end

    // Prescaler and per-state second counter restart on every state entry,
    // so an N-second state lasts exactly N*SEC cycles.
    always_comb begin
        presc_d = presc_q + 24'd1;
        sec_d   = sec_q;
        if (intrare) begin
            presc_d = 24'd0;
            sec_d   = 5'd0;
        end else if (tick) begin
            presc_d = 24'd0;
            sec_d   = sec_q + 5'd1;
        end
    end

    // Registered outputs: entry values are loaded on the same edge as the
    // state change; within a state only ticks change them.
    always_comb begin
        csv_d    = csv_q;
        verde_d  = verde_q;
        rosu_d   = rosu_q;
        afisaj_d = afisaj_q;
        if (intrare) begin
            csv_d    = 1'b0;
            verde_d  = 1'b0;
            rosu_d   = 1'b1;
            afisaj_d = 5'd0;
            case (stare_d)
                PREDARE: csv_d = 1'b1;
                VERDE: begin
                    verde_d  = 1'b1;
                    rosu_d   = 1'b0;
                    afisaj_d = VERDE_LOAD;
                end
                CLIPIRE: begin
                    rosu_d   = 1'b0;
                    afisaj_d = CLIP_LOAD;
                end
                default: ;
            endcase
        end else if (tick) begin
            case (stare_q)
                VERDE: begin
                    if (afisaj_q != 5'd0) afisaj_d = afisaj_q - 5'd1;
                end
                CLIPIRE: begin
                    verde_d = ~verde_q;
                    if (afisaj_q != 5'd0) afisaj_d = afisaj_q - 5'd1;
                end
                MENTENANTA: rosu_d = ~rosu_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cv_meta_q  <= 1'b0;
            cv_s_q     <= 1'b0;
            int_meta_q <= 1'b0;
            int_s_q    <= 1'b0;
            stare_q    <= PREDARE;
            presc_q    <= 24'd0;
            sec_q      <= 5'd0;
            csv_q      <= 1'b1;
            verde_q    <= 1'b0;
            rosu_q     <= 1'b1;
            afisaj_q   <= 5'd0;
        end else begin
            cv_meta_q  <= Continuare_v;
            cv_s_q     <= cv_meta_q;
            int_meta_q <= intretinere;
            int_s_q    <= int_meta_q;
            stare_q    <= stare_d;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            csv_q      <= csv_d;
            verde_q    <= verde_d;
            rosu_q     <= rosu_d;
            afisaj_q   <= afisaj_d;
        end
    end

    assign Continuare_s_v = csv_q;
    assign Verde_pieton   = verde_q;
    assign Rosu_pieton    = rosu_q;
    assign afisaj         = afisaj_q;
    assign stare_o        = stare_q;

endmodule

// File: tb/tb_semafor_pietoni.sv
// tb_semafor_pietoni
// ------------------
// Directed bench for semafor_pietoni with SEC=4, T_SIGURANTA=1, T_VERDE=3,
// T_CLIPIRE=2. Inputs are driven and outputs sampled on the falling clock
// edge; the DUT acts on the rising edge. The lamp vector is
// {Continuare_s_v, Rosu_pieton, Verde_pieton, afisaj[4:0]}.

module tb_semafor_pietoni;

    localparam logic [2:0] S_PREDARE    = 3'd0;
    localparam logic [2:0] S_ASTEPTARE  = 3'd1;
    localparam logic [2:0] S_SIGURANTA  = 3'd2;
    localparam logic [2:0] S_VERDE      = 3'd3;
    localparam logic [2:0] S_CLIPIRE    = 3'd4;
    localparam logic [2:0] S_MENTENANTA = 3'd5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       intretinere = 1'b0;
    logic       Continuare_v = 1'b0;
    logic       Continuare_s_v;
    logic       Verde_pieton;
    logic       Rosu_pieton;
    logic [4:0] afisaj;
    logic [2:0] stare_o;
    logic [7:0] lamps;

    int tests = 0;
    int failed = 0;

    assign lamps = {Continuare_s_v, Rosu_pieton, Verde_pieton, afisaj};

    semafor_pietoni #(
        .SEC         (24'd4),
        .T_SIGURANTA (1),
        .T_VERDE     (3),
        .T_CLIPIRE   (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .intretinere    (intretinere),
        .Continuare_v   (Continuare_v),
        .Continuare_s_v (Continuare_s_v),
        .Verde_pieton   (Verde_pieton),
        .Rosu_pieton    (Rosu_pieton),
        .afisaj         (afisaj),
        .stare_o        (stare_o)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        step(3);
        tests++;
        if (lamps !== 8'b1_1_0_00000) begin
            failed++;
            $display("FAIL reset_lamps: got %b expected %b", lamps, 8'b1_1_0_00000);
        end
        tests++;
        if (stare_o !== S_PREDARE) begin
            failed++;
            $display("FAIL reset_state: got %0d expected %0d", stare_o, S_PREDARE);
        end
    endtask

    // Called at a falling edge with reset asserted and Continuare_v low.
    task automatic test_release();
        reset = 1'b1;
        #1;
        tests++;
        if (lamps !== 8'b1_1_0_00000) begin
            failed++;
            $display("FAIL release_start: got %b expected %b", lamps, 8'b1_1_0_00000);
        end
        step(1);
        tests++;
        if (lamps !== 8'b0_1_0_00000 || stare_o !== S_ASTEPTARE) begin
            failed++;
            $display("FAIL release_pulse_end: got %b state %0d expected %b state %0d",
                     lamps, stare_o, 8'b0_1_0_00000, S_ASTEPTARE);
        end
        step(1);
        tests++;
        if (lamps !== 8'b0_1_0_00000 || stare_o !== S_ASTEPTARE) begin
            failed++;
            $display("FAIL release_wait: got %b state %0d expected %b state %0d",
                     lamps, stare_o, 8'b0_1_0_00000, S_ASTEPTARE);
        end
    endtask

    task automatic test_green_phase();
        logic [7:0] exp;
        Continuare_v = 1'b1;
        step(2);
        tests++;
        if (stare_o !== S_ASTEPTARE) begin
            failed++;
            $display("FAIL sync_latency_early: got %0d expected %0d", stare_o, S_ASTEPTARE);
        end
        step(1);
        // Clearance: red for 4 cycles starting at SIGURANTA entry.
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(1);
            tests++;
            if (lamps !== 8'b0_1_0_00000 || stare_o !== S_SIGURANTA) begin
                failed++;
                $display("FAIL clearance[%0d]: got %b state %0d expected %b state %0d",
                         i, lamps, stare_o, 8'b0_1_0_00000, S_SIGURANTA);
            end
        end
        // Steady green: countdown 5,4,3, each for 4 cycles.
        for (int i = 0; i < 12; i++) begin
            step(1);
            exp = {3'b001, 5'(5 - i / 4)};
            tests++;
            if (lamps !== exp || stare_o !== S_VERDE) begin
                failed++;
                $display("FAIL green[%0d]: got %b state %0d expected %b state %0d",
                         i, lamps, stare_o, exp, S_VERDE);
            end
        end
    endtask

    task automatic test_blink_phase();
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) begin
            step(1);
            exp = (i < 4) ? 8'b0_0_0_00010 : 8'b0_0_1_00001;
            tests++;
            if (lamps !== exp || stare_o !== S_CLIPIRE) begin
                failed++;
                $display("FAIL blink[%0d]: got %b state %0d expected %b state %0d",
                         i, lamps, stare_o, exp, S_CLIPIRE);
            end
        end
        step(1);
        tests++;
        if (lamps !== 8'b1_1_0_00000 || stare_o !== S_PREDARE) begin
            failed++;
            $display("FAIL handback: got %b state %0d expected %b state %0d",
                     lamps, stare_o, 8'b1_1_0_00000, S_PREDARE);
        end
    endtask

    task automatic test_hold_done();
        for (int i = 0; i < 10; i++) begin
            step(1);
            tests++;
            if (lamps !== 8'b1_1_0_00000 || stare_o !== S_PREDARE) begin
                failed++;
                $display("FAIL hold[%0d]: got %b state %0d expected %b state %0d",
                         i, lamps, stare_o, 8'b1_1_0_00000, S_PREDARE);
            end
        end
        Continuare_v = 1'b0;
        step(2);
        tests++;
        if (lamps !== 8'b1_1_0_00000 || stare_o !== S_PREDARE) begin
            failed++;
            $display("FAIL drop_early: got %b state %0d expected %b state %0d",
                     lamps, stare_o, 8'b1_1_0_00000, S_PREDARE);
        end
        step(1);
        tests++;
        if (lamps !== 8'b0_1_0_00000 || stare_o !== S_ASTEPTARE) begin
            failed++;
            $display("FAIL drop_fall: got %b state %0d expected %b state %0d",
                     lamps, stare_o, 8'b0_1_0_00000, S_ASTEPTARE);
        end
    endtask

    task automatic test_maintenance();
        logic [7:0] exp;
        Continuare_v = 1'b1;
        step(3 + 4 + 5);
        tests++;
        if (lamps !== 8'b0_0_1_00100 || stare_o !== S_VERDE) begin
            failed++;
            $display("FAIL mid_green: got %b state %0d expected %b state %0d",
                     lamps, stare_o, 8'b0_0_1_00100, S_VERDE);
        end
        intretinere = 1'b1;
        step(2);
        tests++;
        if (stare_o !== S_VERDE || Verde_pieton !== 1'b1) begin
            failed++;
            $display("FAIL maint_early: got state %0d verde %b expected state %0d verde 1",
                     stare_o, Verde_pieton, S_VERDE);
        end
        // Red blinks with a 4-cycle half period starting high at entry.
        for (int i = 0; i < 12; i++) begin
            step(1);
            exp = {1'b0, (((i / 4) % 2) == 0), 1'b0, 5'd0};
            tests++;
            if (lamps !== exp || stare_o !== S_MENTENANTA) begin
                failed++;
                $display("FAIL maint[%0d]: got %b state %0d expected %b state %0d",
                         i, lamps, stare_o, exp, S_MENTENANTA);
            end
        end
        intretinere = 1'b0;
        step(2);
        tests++;
        if (stare_o !== S_MENTENANTA) begin
            failed++;
            $display("FAIL maint_exit_early: got %0d expected %0d", stare_o, S_MENTENANTA);
        end
        step(1);
        tests++;
        if (lamps !== 8'b1_1_0_00000 || stare_o !== S_PREDARE) begin
            failed++;
            $display("FAIL maint_exit: got %b state %0d expected %b state %0d",
                     lamps, stare_o, 8'b1_1_0_00000, S_PREDARE);
        end
    endtask

    task automatic test_reset_mid_clipire();
        Continuare_v = 1'b0;
        step(3);
        tests++;
        if (stare_o !== S_ASTEPTARE) begin
            failed++;
            $display("FAIL rst_setup: got %0d expected %0d", stare_o, S_ASTEPTARE);
        end
        Continuare_v = 1'b1;
        step(3 + 4 + 12);
        tests++;
        if (lamps !== 8'b0_0_0_00010 || stare_o !== S_CLIPIRE) begin
            failed++;
            $display("FAIL rst_clipire_entry: got %b state %0d expected %b state %0d",
                     lamps, stare_o, 8'b0_0_0_00010, S_CLIPIRE);
        end
        step(2);
        #2;
        reset = 1'b0;
        Continuare_v = 1'b0;
        #1;
        tests++;
        if (lamps !== 8'b1_1_0_00000 || stare_o !== S_PREDARE) begin
            failed++;
            $display("FAIL rst_async: got %b state %0d expected %b state %0d",
                     lamps, stare_o, 8'b1_1_0_00000, S_PREDARE);
        end
        step(2);
        tests++;
        if (lamps !== 8'b1_1_0_00000 || stare_o !== S_PREDARE) begin
            failed++;
            $display("FAIL rst_held: got %b state %0d expected %b state %0d",
                     lamps, stare_o, 8'b1_1_0_00000, S_PREDARE);
        end
        test_release();
    endtask

    initial begin
        test_reset();
        test_release();
        test_green_phase();
        test_blink_phase();
        test_hold_done();
        test_maintenance();
        test_reset_mid_clipire();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/semafor_pietoni.md
# semafor_pietoni

Pedestrian-crossing controller forming the other end of the vehicle-light handoff: it waits for the vehicle module to report its cycle done (`Continuare_v`), runs a timed pedestrian phase, then hands control back by driving `Continuare_s_v`. It shares the system clock with the vehicle module and uses its own one-second prescaler. Pedestrian green is only ever shown while the vehicle side sits in its red "done" state.

## Interface
- `SEC`, 24'd10000000: clock cycles per one-second tick (≥2).
- `T_SIGURANTA`, 1: all-red clearance before pedestrian green, in seconds.
- `T_VERDE`, 10: steady pedestrian green, in seconds.
- `T_CLIPIRE`, 4: blinking pedestrian green, in seconds. `T_VERDE+T_CLIPIRE` ≤ 31.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-low reset.
- `intretinere` in 1: maintenance request, asynchronous level.
- `Continuare_v` in 1: vehicle cycle done, asynchronous level; high while the vehicle module is in its Done state.
- `Continuare_s_v` out 1: start request to the vehicle module; the vehicle side acts on its rising edge.
- `Verde_pieton` out 1: pedestrian green lamp.
- `Rosu_pieton` out 1: pedestrian red lamp.
- `afisaj` out 5: seconds remaining in the pedestrian phase; 0 outside green.

## Operation
- `Continuare_v` and `intretinere` each pass through a 2-flop synchronizer. All decisions use the synchronized values (`cv_s`, `int_s`).
- The prescaler counts 0..SEC-1. `tick` is a one-cycle pulse when count = SEC-1. The prescaler and the per-state second counter both clear on every state entry, so a state lasting N seconds lasts exactly N×SEC cycles.
- States and transitions:
  - PREDARE: Rosu=1, Verde=0, Continuare_s_v=1. Minimum 1 cycle. Exit to ASTEPTARE when `cv_s`=0.
  - ASTEPTARE: Rosu=1, Continuare_s_v=0. Exit to SIGURANTA when `cv_s`=1.
  - SIGURANTA: Rosu=1. Exit to VERDE after T_SIGURANTA ticks.
  - VERDE: Verde=1, Rosu=0. `afisaj` loads T_VERDE+T_CLIPIRE on entry and decrements on each tick. Exit to CLIPIRE after T_VERDE ticks.
  - CLIPIRE: Rosu=0. Verde starts at 0 on entry and toggles on each tick. `afisaj` loads T_CLIPIRE on entry and decrements on each tick. Exit to PREDARE after T_CLIPIRE ticks.
  - MENTENANTA: Verde=0, Continuare_s_v=0, `afisaj`=0. Rosu starts at 1 and toggles on each tick. Exit to PREDARE when `int_s`=0.
- `int_s`=1 forces MENTENANTA from any state, with priority over all other transitions.
- `afisaj`=0 in every state except VERDE and CLIPIRE. It never underflows.
- Outputs are registered and update on the same edge as the state change. They do not glitch.

## Timing
- Reset (async assert): state PREDARE, Continuare_s_v=1, Rosu_pieton=1, Verde_pieton=0, `afisaj`=0, prescaler=0, synchronizers=0.
- After reset release, PREDARE issues the initial start to the vehicle module. With `Continuare_v` low, the block moves to ASTEPTARE on the first edge, so Continuare_s_v is a 1-cycle pulse.
- A rising edge on `Continuare_v` reaches SIGURANTA on the 3rd rising clk edge after the input changes.
- From SIGURANTA entry, Verde_pieton rises after exactly T_SIGURANTA×SEC cycles.
- In PREDARE, Continuare_s_v stays high until `cv_s` falls. Fall latency is 3 edges after `Continuare_v` falls.
- A `Continuare_v` pulse shorter than 2 cycles may be missed; the vehicle module holds it for at least one second.
- `intretinere` is honoured 3 edges after it rises.
- Reset asserted mid-phase returns to the reset values immediately. No partial countdown resumes.
- `Continuare_v` dropping during SIGURANTA, VERDE or CLIPIRE is ignored; the phase completes.

## Test plan
Bench parameters: SEC=4, T_SIGURANTA=1, T_VERDE=3, T_CLIPIRE=2.
- Release reset with `Continuare_v`=0 -> Continuare_s_v high for exactly 1 cycle after release; Rosu=1; state ASTEPTARE.
- Raise `Continuare_v` and hold it -> Rosu high for 4 cycles after SIGURANTA entry, then Verde=1 for 12 cycles; `afisaj` reads 5,4,3, each for 4 cycles.
- Continue the previous scenario -> in CLIPIRE, Verde reads 0 for 4 cycles then 1 for 4 cycles, `afisaj` reads 2 then 1; then PREDARE with Rosu=1, Continuare_s_v=1, `afisaj`=0.
- In PREDARE with `Continuare_v` still high, drop it 10 cycles later -> Continuare_s_v stays high until 3 edges after the drop, then falls; block returns to ASTEPTARE.
- Assert `intretinere` mid-VERDE -> within 3 edges Verde=0, `afisaj`=0, Rosu=1, then Rosu toggles every 4 cycles. On release -> PREDARE with Continuare_s_v=1.
- Assert `reset` mid-CLIPIRE between clock edges -> outputs immediately take the reset values. After release, the sequence restarts as in the first scenario.
